cacheline_adapter: RTL
======================

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 Parameters SHALL be LINE_W, default 256, cache line width in bits.
REQ-002 Parameters SHALL include BEAT_W, default 64, memory beat width in bits; beat count is LINE_W/BEAT_W = 4.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 up_addr  in  32  line address from the arbiter.
REQ-006 up_read  in  1  line-read request.
REQ-007 up_write  in  1  line-write request.
REQ-008 up_wdata  in  LINE_W  line to write.
REQ-009 up_ready  out  1  adapter idle and able to accept a request.
REQ-010 up_rdata  out  LINE_W  assembled read line.
REQ-011 up_rvalid  out  1  one-cycle pulse: up_rdata valid.
REQ-012 up_wdone  out  1  one-cycle pulse: line write complete.
REQ-013 bmem_addr  out  32  memory address, bits [4:0] always zero.
REQ-014 bmem_read  out  1  memory read command.
REQ-015 bmem_write  out  1  memory write beat valid.
REQ-016 bmem_wdata  out  BEAT_W  write beat.
REQ-017 bmem_ready  in  1  memory accepts a command or beat this cycle.
REQ-018 bmem_raddr  in  32  address tag of the returning beat.
REQ-019 bmem_rdata  in  BEAT_W  returning read beat.
REQ-020 bmem_rvalid  in  1  bmem_rdata valid.

Function
REQ-021 FSM states SHALL be IDLE, RD_REQ, RD_DATA, WR_DATA, DONE; up_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, up_write=1 SHALL latch up_addr (low 5 bits cleared) and up_wdata, then go to WR_DATA; up_write has priority when up_read is also 1, and that read is dropped.
REQ-023 In IDLE, up_read=1 with up_write=0 SHALL latch the aligned address and go to RD_REQ.
REQ-024 Requests presented outside IDLE SHALL be ignored; the arbiter must hold them until up_ready.
REQ-025 RD_REQ: bmem_read=1, bmem_addr=latched address; hold in RD_REQ until an edge with bmem_ready=1, then go to RD_DATA; bmem_read SHALL be 1 only in RD_REQ.
REQ-026 RD_DATA: each edge with bmem_rvalid=1 and bmem_raddr equal to the latched address SHALL store bmem_rdata into slice [beat*64 +: 64] and increment a 2-bit beat counter from 0.
REQ-027 Beats whose bmem_raddr differs from the latched address SHALL be discarded without advancing the counter.
REQ-028 The edge storing beat 3 SHALL move the FSM to DONE; up_rvalid=1 in DONE for a read.
REQ-029 up_rdata SHALL be held until the next read completes.
REQ-030 WR_DATA: bmem_write=1, bmem_addr=latched address, bmem_wdata=line slice [beat*64 +: 64].
REQ-031 In WR_DATA the beat SHALL advance only on edges with bmem_ready=1; with bmem_ready=0 all outputs hold.
REQ-032 The edge that accepts beat 3 SHALL move the FSM to DONE; up_wdone=1 in DONE for a write.
REQ-033 DONE SHALL last exactly one cycle and then return to IDLE; up_rvalid and up_wdone are never both 1.
REQ-034 Minimum latency SHALL be: write accept to up_wdone = 5 cycles; read accept to up_rvalid = 2 cycles plus beat arrival time.

Reset
REQ-035 Asserting rst SHALL immediately force IDLE, clear the beat counter, and clear up_rdata, bmem_addr, bmem_wdata and every control output to 0; up_ready becomes 1.
REQ-036 Reset mid-operation SHALL abandon the transfer with no pulse; beats arriving after reset SHALL be ignored.

Structure
REQ-037 The state enum, LINE_W, BEAT_W and BEATS SHALL live in the shared package mem_types_pkg.
REQ-038 Beat slicing and assembly SHALL be a single sub-module, line_beat_buf (line register plus beat-indexed read/write ports); the FSM stays in cacheline_adapter.

Verification
REQ-039 Read, no stalls: up_read, addr 0x1ECEB004; beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> bmem_addr 0x1ECEB000, one bmem_read cycle, up_rvalid once, up_rdata = {0x44..,0x33..,0x22..,0x11..}.
REQ-040 Write with stall: up_write, addr 0x00001020, wdata = 4 distinct beats; bmem_ready low for 2 cycles during beat 1 -> beats 0..3 in order, beat 1 held 3 cycles, up_wdone once, 7 cycles after accept.
REQ-041 Simultaneous up_read=1 and up_write=1 -> write performed, no bmem_read issued, up_rvalid never asserted.
REQ-042 Foreign beat: beat with bmem_raddr 0x2000 interleaved during a read of 0x1000 -> beat ignored, line assembled from the 4 matching beats only.
REQ-043 rst asserted after read beat 2 -> outputs immediately 0 and up_ready 1; remaining beats ignored; a following write completes normally.

Source files
------------

// File: rtl/mem_types_pkg.sv
// Shared memory-side types for the cache line adapter: line/beat geometry and
// the adapter FSM state encoding.
package mem_types_pkg;

  localparam int LINE_W  = 256;
  localparam int BEAT_W  = 64;
  localparam int BEATS   = LINE_W / BEAT_W;
  localparam int BEAT_IW = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/line_beat_buf.sv
// Line register with beat-indexed read/write ports, plus a committed copy of
// the last fully assembled read line.
module line_beat_buf #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int IW     = $clog2(LINE_W / BEAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_beat,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              commit,
  input  logic [IW-1:0]     rd_beat,
  output logic [BEAT_W-1:0] rd_data,
  output logic [LINE_W-1:0] line_out
);

  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] merged;

  // merged includes the beat being written this cycle, so a commit on the
  // final beat captures the complete line in one edge.
  always_comb begin
    merged = line;
    if (wr_en) merged[wr_beat*BEAT_W +: BEAT_W] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line     <= '0;
      line_out <= '0;
    end else begin
      if (load)       line <= load_line;
      else if (wr_en) line <= merged;
      if (commit)     line_out <= merged;
    end
  end

  assign rd_data = line[rd_beat*BEAT_W +: BEAT_W];

endmodule

// File: rtl/cacheline_adapter.sv
// Converts whole-line read/write requests into a burst of memory beats:
// one read command then tagged returning beats, or a stream of write beats.
module cacheline_adapter #(
  parameter int LINE_W = mem_types_pkg::LINE_W,
  parameter int BEAT_W = mem_types_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       up_addr,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [LINE_W-1:0] up_wdata,
  output logic              up_ready,
  output logic [LINE_W-1:0] up_rdata,
  output logic              up_rvalid,
  output logic              up_wdone,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic [2:0]        fsm_state
);
  import mem_types_pkg::*;

  localparam int            IW        = $clog2(LINE_W / BEAT_W);
  localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_W / BEAT_W - 1);
  localparam logic [31:0]   ADDR_MASK = 32'hFFFF_FFE0;

  state_t            state;
  logic [IW-1:0]     beat;
  logic [31:0]       addr;
  logic              beat_hit;
  logic              commit;
  logic [BEAT_W-1:0] beat_data;

  // Handshakes: a command (bmem_read) or write beat (bmem_write) transfers on
  // a rising edge where bmem_ready=1; a read beat transfers on any edge with
  // bmem_rvalid=1 and a matching bmem_raddr; upstream requests transfer on an
  // edge where up_ready=1, and the caller must hold them until then.
  assign beat_hit = (state == RD_DATA) && bmem_rvalid && (bmem_raddr == addr);
  assign commit   = beat_hit && (beat == LAST_BEAT);

  line_beat_buf #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IW     (IW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      ((state == IDLE) && up_write),
    .load_line (up_wdata),
    .wr_en     (beat_hit),
    .wr_beat   (beat),
    .wr_data   (bmem_rdata),
    .commit    (commit),
    .rd_beat   (beat),
    .rd_data   (beat_data),
    .line_out  (up_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= '0;
      addr       <= '0;
      up_ready   <= 1'b1;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      up_rvalid  <= 1'b0;
      up_wdone   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A write wins over a simultaneous read; that read is dropped.
          if (up_write) begin
            addr       <= up_addr & ADDR_MASK;
            beat       <= '0;
            bmem_write <= 1'b1;
            up_ready   <= 1'b0;
            state      <= WR_DATA;
          end else if (up_read) begin
            addr      <= up_addr & ADDR_MASK;
            bmem_read <= 1'b1;
            up_ready  <= 1'b0;
            state     <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            beat      <= '0;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (beat_hit) begin
            beat <= beat + IW'(1);
            if (beat == LAST_BEAT) begin
              up_rvalid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        WR_DATA: begin
          if (bmem_ready) begin
            beat <= beat + IW'(1);
            if (beat == LAST_BEAT) begin
              bmem_write <= 1'b0;
              up_wdone   <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          up_rvalid <= 1'b0;
          up_wdone  <= 1'b0;
          up_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bmem_addr  = addr;
  assign bmem_wdata = bmem_write ? beat_data : '0;
  assign fsm_state  = state;

endmodule
